// File: rtl/hazard_fwd_unit_if.sv
// Bus between the ID/EX pipeline control and the hazard/forwarding unit.
`default_nettype none

interface hazard_fwd_unit_if #(
  parameter int CNT_W = 32
);

  logic [31:0]      inst_id;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_rf_we;
  logic             is_load_id;
  logic             is_branch;
  logic [31:0]      ex_alu_c;
  logic [31:0]      mem_wd;
  logic [31:0]      wb_wd;
  logic             load_stop;
  logic             rd1_sel;
  logic             rd2_sel;
  logic [31:0]      rdata1_f;
  logic [31:0]      rdata2_f;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: supplies the ID instruction and stage data, consumes controls.
  modport master (
    output inst_id, id_use_rs1, id_use_rs2, id_rf_we, is_load_id, is_branch,
    output ex_alu_c, mem_wd, wb_wd,
    input  load_stop, rd1_sel, rd2_sel, rdata1_f, rdata2_f, stall_cnt, flush_cnt
  );

  modport slave (
    input  inst_id, id_use_rs1, id_use_rs2, id_rf_we, is_load_id, is_branch,
    input  ex_alu_c, mem_wd, wb_wd,
    output load_stop, rd1_sel, rd2_sel, rdata1_f, rdata2_f, stall_cnt, flush_cnt
  );

endinterface

`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: load-use stall detection, youngest-producer operand forwarding,
// and saturating stall/flush event counters. Rev 1.0.
`default_nettype none

module hazard_fwd_unit #(
  parameter int CNT_W = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  hazard_fwd_unit_if.slave   bus
);

  // Shadow occupancy of the downstream stages.
  logic [4:0]       ex_rd_q,  ex_rd_d;
  logic             ex_we_q,  ex_we_d;
  logic             ex_ld_q,  ex_ld_d;
  logic [4:0]       mem_rd_q, mem_rd_d;
  logic             mem_we_q, mem_we_d;
  logic [4:0]       wb_rd_q,  wb_rd_d;
  logic             wb_we_q,  wb_we_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [4:0]  w_rs       [2];
  logic        w_use      [2];
  logic        w_ex_match [2];
  logic        w_mem_match[2];
  logic        w_wb_match [2];
  logic        w_sel      [2];
  logic [31:0] w_fwd      [2];
  logic        w_hz;
  logic        w_load_stop;
  logic        w_unused_inst;

  assign w_rs[0]  = bus.inst_id[19:15];
  assign w_rs[1]  = bus.inst_id[24:20];
  assign w_use[0] = bus.id_use_rs1;
  assign w_use[1] = bus.id_use_rs2;

  // Opcode/funct fields are decoded elsewhere; only register indices matter here.
  assign w_unused_inst = ^{bus.inst_id[31:25], bus.inst_id[14:12], bus.inst_id[6:0]};

  function automatic logic producer_match(
    input logic       we,
    input logic [4:0] rd,
    input logic [4:0] rs,
    input logic       use_rs
  );
    return we && (rd != 5'd0) && (rd == rs) && use_rs;
  endfunction

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_ex_match[n]  = producer_match(ex_we_q,  ex_rd_q,  w_rs[n], w_use[n]);
      w_mem_match[n] = producer_match(mem_we_q, mem_rd_q, w_rs[n], w_use[n]);
      w_wb_match[n]  = producer_match(wb_we_q,  wb_rd_q,  w_rs[n], w_use[n]);
    end
  end

  // A load in EX has no data yet; it stalls instead of forwarding.
  assign w_hz        = ex_ld_q && (w_ex_match[0] || w_ex_match[1]);
  assign w_load_stop = w_hz && !bus.is_branch;

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      w_sel[n] = 1'b0;
      w_fwd[n] = 32'd0;
      if (w_ex_match[n] && !ex_ld_q) begin
        w_sel[n] = 1'b1;
        w_fwd[n] = bus.ex_alu_c;
      end else if (w_mem_match[n]) begin
        w_sel[n] = 1'b1;
        w_fwd[n] = bus.mem_wd;
      end else if (w_wb_match[n]) begin
        w_sel[n] = 1'b1;
        w_fwd[n] = bus.wb_wd;
      end
    end
  end

  always_comb begin
    wb_rd_d  = mem_rd_q;
    wb_we_d  = mem_we_q;
    mem_rd_d = ex_rd_q;
    mem_we_d = ex_we_q;
    ex_rd_d  = bus.inst_id[11:7];
    ex_we_d  = bus.id_rf_we;
    ex_ld_d  = bus.is_load_id;
    // A killed or held ID instruction must not appear as a producer in EX.
    if (bus.is_branch || w_load_stop) begin
      ex_rd_d = 5'd0;
      ex_we_d = 1'b0;
      ex_ld_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (w_load_stop && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (bus.is_branch && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_q     <= 5'd0;
      ex_we_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      mem_rd_q    <= 5'd0;
      mem_we_q    <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_we_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_rd_q     <= ex_rd_d;
      ex_we_q     <= ex_we_d;
      ex_ld_q     <= ex_ld_d;
      mem_rd_q    <= mem_rd_d;
      mem_we_q    <= mem_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_we_q     <= wb_we_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.load_stop = w_load_stop;
  assign bus.rd1_sel   = w_sel[0];
  assign bus.rd2_sel   = w_sel[1];
  assign bus.rdata1_f  = w_fwd[0];
  assign bus.rdata2_f  = w_fwd[1];
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
// Directed self-checking bench for hazard_fwd_unit with a narrow counter width.
`default_nettype none

module tb_hazard_fwd_unit;

  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  hazard_fwd_unit_if #(.CNT_W(CNT_W)) bus ();

  hazard_fwd_unit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic we,
                        input logic ld, input logic br);
    bus.inst_id    = {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    bus.id_use_rs1 = u1;
    bus.id_use_rs2 = u2;
    bus.id_rf_we   = we;
    bus.is_load_id = ld;
    bus.is_branch  = br;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".load_stop"}, 32'(bus.load_stop), 32'd0);
    chk({tag, ".rd1_sel"},   32'(bus.rd1_sel),   32'd0);
    chk({tag, ".rd2_sel"},   32'(bus.rd2_sel),   32'd0);
    chk({tag, ".rdata1_f"},  bus.rdata1_f,       32'd0);
    chk({tag, ".rdata2_f"},  bus.rdata2_f,       32'd0);
    chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'd0);
    chk({tag, ".flush_cnt"}, 32'(bus.flush_cnt), 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.ex_alu_c = 32'h1111_1111;
    bus.mem_wd   = 32'h2222_2222;
    bus.wb_wd    = 32'h3333_3333;

    // Power-on reset.
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("por");

    // Release; an independent instruction forwards nothing.
    @(negedge clk);
    rst_n = 1'b1;
    set_id(5'd20, 5'd21, 5'd22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("indep.rd1_sel", 32'(bus.rd1_sel), 32'd0);
    chk("indep.rd2_sel", 32'(bus.rd2_sel), 32'd0);

    // ADD x5 then ADD x6,x5,x1: EX forwarding on rs1 only.
    @(negedge clk);
    set_id(5'd5, 5'd10, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("add5.rd1_sel", 32'(bus.rd1_sel), 32'd0);
    @(negedge clk);
    set_id(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.ex_alu_c = 32'h0000_1234;
    bus.mem_wd   = 32'h0000_0055;
    bus.wb_wd    = 32'h0000_0066;
    #1;
    chk("exfwd.rd1_sel",   32'(bus.rd1_sel),   32'd1);
    chk("exfwd.rdata1_f",  bus.rdata1_f,       32'h0000_1234);
    chk("exfwd.rd2_sel",   32'(bus.rd2_sel),   32'd0);
    chk("exfwd.rdata2_f",  bus.rdata2_f,       32'd0);
    chk("exfwd.load_stop", 32'(bus.load_stop), 32'd0);

    // LW x7 then ADD x8,x7,x7: one stall cycle, then MEM forwarding.
    @(negedge clk);
    set_id(5'd7, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("lw.load_stop", 32'(bus.load_stop), 32'd0);
    @(negedge clk);
    set_id(5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.mem_wd = 32'hDEAD_BEEF;
    #1;
    chk("lu.load_stop", 32'(bus.load_stop), 32'd1);
    chk("lu.rd1_sel",   32'(bus.rd1_sel),   32'd0);
    chk("lu.stall_cnt", 32'(bus.stall_cnt), 32'd0);
    @(negedge clk);
    #1;
    chk("lu2.load_stop", 32'(bus.load_stop), 32'd0);
    chk("lu2.rd1_sel",   32'(bus.rd1_sel),   32'd1);
    chk("lu2.rd2_sel",   32'(bus.rd2_sel),   32'd1);
    chk("lu2.rdata1_f",  bus.rdata1_f,       32'hDEAD_BEEF);
    chk("lu2.rdata2_f",  bus.rdata2_f,       32'hDEAD_BEEF);
    chk("lu2.stall_cnt", 32'(bus.stall_cnt), 32'd1);

    // x9 produced in EX, MEM and WB at once: the youngest (EX) wins.
    bus.ex_alu_c = 32'd1;
    bus.mem_wd   = 32'd2;
    bus.wb_wd    = 32'd3;
    repeat (3) begin
      @(negedge clk);
      set_id(5'd9, 5'd13, 5'd13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    set_id(5'd10, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("prio.rd1_sel",  32'(bus.rd1_sel), 32'd1);
    chk("prio.rdata1_f", bus.rdata1_f,     32'd1);
    chk("prio.rd2_sel",  32'(bus.rd2_sel), 32'd0);
    bus.id_use_rs1 = 1'b0;
    #1;
    chk("nouse.rd1_sel", 32'(bus.rd1_sel), 32'd0);

    // EX producer writes x0 (a load): MEM wins, and x0 neither forwards nor stalls.
    repeat (2) begin
      @(negedge clk);
      set_id(5'd9, 5'd13, 5'd13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    set_id(5'd0, 5'd13, 5'd13, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    set_id(5'd10, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("x0.rdata1_f",  bus.rdata1_f,       32'd2);
    chk("x0.rd1_sel",   32'(bus.rd1_sel),   32'd1);
    chk("x0.rd2_sel",   32'(bus.rd2_sel),   32'd0);
    chk("x0.load_stop", 32'(bus.load_stop), 32'd0);

    // Asynchronous reset while a load-use hazard is pending.
    @(negedge clk);
    set_id(5'd7, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    set_id(5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("prerst.load_stop", 32'(bus.load_stop), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    set_id(5'd20, 5'd21, 5'd22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("postrst.rd1_sel", 32'(bus.rd1_sel), 32'd0);
    chk("postrst.rd2_sel", 32'(bus.rd2_sel), 32'd0);

    // Branch together with a load-use hazard: flush wins over stall.
    @(negedge clk);
    set_id(5'd7, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    set_id(5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    chk("br.load_stop", 32'(bus.load_stop), 32'd0);
    chk("br.flush_cnt", 32'(bus.flush_cnt), 32'd0);
    @(negedge clk);
    set_id(5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.ex_alu_c = 32'h0000_AAAA;
    bus.mem_wd   = 32'h0000_5555;
    #1;
    chk("br2.flush_cnt", 32'(bus.flush_cnt), 32'd1);
    chk("br2.stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("br2.load_stop", 32'(bus.load_stop), 32'd0);
    chk("br2.rd1_sel",   32'(bus.rd1_sel),   32'd1);
    chk("br2.rdata1_f",  bus.rdata1_f,       32'h0000_5555);

    // Twenty load-use stalls: the 4-bit counter saturates at 15.
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      set_id(5'd7, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      set_id(5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      chk("sat.load_stop", 32'(bus.load_stop), 32'd1);
      @(negedge clk);
      #1;
      chk("sat.stall_cnt", 32'(bus.stall_cnt), (k > 15) ? 32'd15 : 32'(k));
    end
    chk("sat.flush_cnt", 32'(bus.flush_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Produces the ID-stage hazard and forwarding controls consumed by the ID/EX pipeline register: load_stop, rd1_sel/rd2_sel and forwarded operands rdata1_f/rdata2_f.
- Keeps its own shadow of destination-register occupancy for the EX, MEM and WB stages. Detects load-use hazards and selects the youngest valid producer for each ID source operand.
- Keeps saturating stall and flush event counters for debug readout.

Parameters:
- CNT_W, 32, width of the stall/flush counters.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- inst_id  input  32  ID instruction; rs1=[19:15], rs2=[24:20], rd=[11:7]
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- id_rf_we  input  1  ID instruction writes rd
- is_load_id  input  1  ID instruction is a load
- is_branch  input  1  EX redirect; kills the ID instruction this cycle
- ex_alu_c  input  32  EX-stage ALU result
- mem_wd  input  32  MEM-stage write-back data (DRAM data for loads)
- wb_wd  input  32  WB-stage write-back data
- load_stop  output  1  stall ID/IF one cycle, bubble into EX
- rd1_sel  output  1  1 = use rdata1_f for rs1
- rd2_sel  output  1  1 = use rdata2_f for rs2
- rdata1_f  output  32  forwarded rs1 value
- rdata2_f  output  32  forwarded rs2 value
- stall_cnt  output  CNT_W  load_stop cycles, saturating
- flush_cnt  output  CNT_W  is_branch cycles, saturating

Behaviour:
- Shadow state: for each stage s in {ex, mem, wb}, registers s_rd[4:0] and s_we. ex additionally has ex_ld.
- Reset: all shadow registers 0, counters 0. Outputs are therefore load_stop=0, rd*_sel=0, rdata*_f=0.
- Reset mid-operation clears all state immediately (asynchronous); no pending hazard survives.
- Shadow update on every rising edge:
  - wb <= mem
  - mem <= {ex_rd, ex_we}
  - ex <= bubble (rd=0, we=0, ld=0) if is_branch or load_stop, else {inst_id[11:7], id_rf_we, is_load_id}
- Valid producer match for stage s and source rsN: s_we=1, s_rd!=0, s_rd==rsN, and the corresponding id_use_rsN=1.
- Load-use hazard: hz = (ex_ld=1 and ex matches rs1 or rs2).
- load_stop = hz & ~is_branch. A branch flush outranks a stall because the ID instruction is discarded.
- Forwarding, evaluated independently per operand N (combinational from shadow state and data inputs, zero added latency):
  - Priority 1: ex match with ex_ld=0 -> rdN_sel=1, rdata_f=ex_alu_c.
  - Priority 2: mem match -> rdN_sel=1, rdata_f=mem_wd.
  - Priority 3: wb match -> rdN_sel=1, rdata_f=wb_wd.
  - Otherwise rdN_sel=0, rdata_f=0.
  - An ex match with ex_ld=1 does not forward. It raises hz; after the bubble the producer sits in mem and forwards mem_wd next cycle.
- Register x0 never forwards and never stalls.
- Sequencing: a load followed by a dependent instruction gives exactly one load_stop cycle, then mem forwarding.
- Counters:
  - stall_cnt increments on each cycle with load_stop=1.
  - flush_cnt increments on each cycle with is_branch=1.
  - Both saturate at all-ones with no wrap; both update on the same edge when both events occur.
- Simultaneous is_branch and hz: load_stop=0, EX gets a bubble, flush_cnt increments, stall_cnt holds.

Test Plan:
- Reset with rst_n=0 asserted mid-stream -> all outputs 0 and counters 0 in the same cycle; after release, an independent instruction gives rd1_sel=rd2_sel=0.
- ADD x5 then ADD x6,x5,x1 -> second instruction in ID: rd1_sel=1, rdata1_f=ex_alu_c (drive 0x1234), rd2_sel=0, load_stop=0.
- LW x7 then ADD x8,x7,x7 -> load_stop=1 for exactly 1 cycle, stall_cnt=1; next cycle rd1_sel=rd2_sel=1, rdata*_f=mem_wd (drive 0xDEADBEEF), load_stop=0.
- x9 written by EX, MEM and WB producers simultaneously (ex_alu_c=1, mem_wd=2, wb_wd=3) -> rdata1_f=1. With the EX instruction writing x0 instead -> rdata1_f=2.
- LW x7 in EX, dependent instruction in ID, is_branch=1 -> load_stop=0, flush_cnt=1, stall_cnt=0; next cycle ex is a bubble (no forward from EX).
- CNT_W=4, hold hazard pattern for 20 stall cycles -> stall_cnt saturates at 15 and stays 15.
